tile_game_sequencer: RTL and testbench
======================================

// Module: tile_game_sequencer
// PURPOSE
//  Top-level game controller for the piano-tiles datapath. Runs the game state machine,
//  paces the note-chart shifter, and judges PS/2 make codes against the current tile.
//  Also keeps score and lives, and speeds the game up as hits accumulate.
//  Sits between the PS/2 receiver and the chart/shift-register, and drives the LED/VGA status logic.
// PARAMETERS
//  STEP_CYCLES    12_500_000  initial clocks per chart step (0.25 s at 50 MHz)
//  MIN_STEP       2_500_000   floor for the step period after speed-ups
//  SPEEDUP_HITS   8           hits between speed-ups
//  SPEEDUP_DELTA  500_000     period reduction per speed-up
//  COUNT_STEPS    4           lead-in steps before the first judged tile
//  LIVES          3           misses allowed before loss (1..3)
// PORTS
//  CLOCK_50          in   1   system clock
//  reset             in   1   async, active-low
//  received_data     in   8   PS/2 byte
//  received_data_en  in   1   one-cycle strobe: received_data valid
//  chart_key         in   8   current chart entry (combinational from the chart shifter)
//  chart_done        in   1   chart exhausted (no entries left)
//  chart_load        out  1   one-cycle pulse: reload chart from its start
//  chart_step        out  1   one-cycle pulse: advance chart by one entry
//  expected          out  8   tile being judged; EMPTY (8'h05) = no tile
//  score             out  10  hit count, saturates at 999
//  lives             out  2   remaining lives
//  game_state        out  3   IDLE=0 COUNTDOWN=1 PLAY=2 PAUSE=3 LOSE=4 WIN=5
// BEHAVIOUR
//  Reset values: game_state=IDLE, score=0, lives=LIVES, expected=EMPTY, chart_load=0,
//   chart_step=0, period=STEP_CYCLES, tick counter=0, pending=0, break flag=0.
//   Reset mid-game aborts immediately; no pulses are issued while reset is low.
//  Scan filter: F0 sets the break flag. The next byte clears the flag and is discarded.
//   E0 is ignored and leaves the flag unchanged. All other bytes are make codes (mk).
//  FSM transitions:
//   IDLE      -> COUNTDOWN on mk==SPACE(8'h29).
//   COUNTDOWN -> PLAY after COUNT_STEPS ticks; no judging.
//   PLAY      -> PAUSE on mk==SPACE; tick counter frozen.
//   PAUSE     -> PLAY on mk==SPACE; counter resumes from its frozen value.
//   PLAY      -> LOSE when lives reaches 0.
//   PLAY      -> WIN at a tick with chart_done=1 and pending=0.
//   LOSE/WIN  -> COUNTDOWN on mk==SPACE.
//  Entry to COUNTDOWN (including the restart from LOSE/WIN):
//   - pulse chart_load for one cycle;
//   - score=0, lives=LIVES, period=STEP_CYCLES, counter=0, expected=EMPTY.
//  Tick: fires when the counter reaches period-1 in COUNTDOWN/PLAY, then the counter returns to 0.
//  On a PLAY tick, in the same edge:
//   - chart_step=1 for one cycle;
//   - expected<=chart_key;
//   - pending<=(chart_key!=EMPTY).
//   Expected-key latency is 1 clock from the tick.
//  Judging (PLAY only; note keys A/S/D/F = 1C/1B/23/2B):
//   - mk==expected with pending=1: hit; score+1 (saturating); pending<=0.
//   - any other note mk: miss (wrong key, or key pressed with no pending tile).
//   - non-note, non-SPACE mk: ignored.
//   - tick while pending=1: miss (tile expired).
//  Simultaneous key and tick: the key is judged against the old expected first, then the tick is evaluated.
//   Two misses in one cycle cost one life only.
//  Miss: lives-1; at 0 -> LOSE; expected<=EMPTY in LOSE/WIN.
//  Speed-up: each SPEEDUP_HITS-th hit sets period=max(MIN_STEP, period-SPEEDUP_DELTA).
//   The new period applies from the next tick. The period is 24-bit unsigned with no underflow.
// STRUCTURE
//  Shared package piano_pkg: scan codes (SPACE, A, S, D, F, EMPTY, BREAK=F0, EXT=E0) and game_state encoding.
//  Sub-module ps2_make_filter: break/extended stripping; outputs mk_valid and mk_code.
//  Step timer, judge and FSM stay in this module.
// TESTING  (STEP_CYCLES=8, MIN_STEP=4, SPEEDUP_HITS=2, SPEEDUP_DELTA=2, COUNT_STEPS=2, LIVES=3)
//  1 Hold reset low mid-PLAY -> IDLE, score 0, lives 3, expected 05 asynchronously.
//  2 SPACE from IDLE -> chart_load 1 cycle; PLAY after 16 clk; first chart_step fires 8 clk later.
//  3 chart_key=1C, send 1C inside the step -> score 1, no life lost.
//    Then F0,1C -> no change.
//    Then send 1C again -> miss, lives 2.
//  4 Tile 1B never pressed -> at the next tick lives-1.
//    Three expiries -> game_state=LOSE, expected=05.
//  5 Two hits -> tick spacing 8 -> 6.
//    Four more hits -> spacing stays at 4.
//  6 Key 2B in the same cycle as the tick with expected=2B -> hit counted, new tile loaded.
//    chart_done with pending=0 at a tick -> WIN.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared scan codes, game-state encoding and key helpers for the piano-tiles game.
package piano_pkg;

  typedef logic [7:0] scan_t;

  localparam scan_t SC_SPACE = 8'h29;
  localparam scan_t SC_A     = 8'h1C;
  localparam scan_t SC_S     = 8'h1B;
  localparam scan_t SC_D     = 8'h23;
  localparam scan_t SC_F     = 8'h2B;
  localparam scan_t SC_EMPTY = 8'h05;
  localparam scan_t SC_BREAK = 8'hF0;
  localparam scan_t SC_EXT   = 8'hE0;

  localparam logic [2:0] GS_IDLE      = 3'd0;
  localparam logic [2:0] GS_COUNTDOWN = 3'd1;
  localparam logic [2:0] GS_PLAY      = 3'd2;
  localparam logic [2:0] GS_PAUSE     = 3'd3;
  localparam logic [2:0] GS_LOSE      = 3'd4;
  localparam logic [2:0] GS_WIN       = 3'd5;

  function automatic logic is_note(input scan_t code);
    return (code == SC_A) || (code == SC_S) || (code == SC_D) || (code == SC_F);
  endfunction

endpackage

// File: rtl/tile_game_sequencer_if.sv
// Bundle of keyboard, chart-shifter and status signals around the game sequencer.
interface tile_game_sequencer_if;
  import piano_pkg::*;

  scan_t       received_data;
  logic        received_data_en;
  scan_t       chart_key;
  logic        chart_done;
  logic        chart_load;
  logic        chart_step;
  scan_t       expected;
  logic [9:0]  score;
  logic [1:0]  lives;
  logic [2:0]  game_state;

  modport master (
    input  received_data, received_data_en, chart_key, chart_done,
    output chart_load, chart_step, expected, score, lives, game_state
  );

  modport slave (
    output received_data, received_data_en, chart_key, chart_done,
    input  chart_load, chart_step, expected, score, lives, game_state
  );

endinterface

// File: rtl/ps2_make_filter.sv
// Strips PS/2 break sequences (F0 xx) and extended prefixes (E0), passing make codes through.
module ps2_make_filter
  import piano_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  data_en,
  input  scan_t data,
  output logic  mk_valid,
  output scan_t mk_code
);

  logic break_q, break_d;

  // The byte after F0 is the released key and is swallowed; E0 never touches the flag.
  always_comb begin
    break_d  = break_q;
    mk_valid = 1'b0;
    mk_code  = data;
    if (data_en) begin
      if (data == SC_BREAK) begin
        break_d = 1'b1;
      end else if (data != SC_EXT) begin
        if (break_q) break_d  = 1'b0;
        else         mk_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) break_q <= 1'b0;
    else        break_q <= break_d;
  end

endmodule

// File: rtl/tile_game_sequencer.sv
// Piano-tiles game controller: FSM, chart step timer, key judging, score/lives and speed-up.
module tile_game_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned STEP_CYCLES   = 12_500_000,
  parameter int unsigned MIN_STEP      = 2_500_000,
  parameter int unsigned SPEEDUP_HITS  = 8,
  parameter int unsigned SPEEDUP_DELTA = 500_000,
  parameter int unsigned COUNT_STEPS   = 4,
  parameter int unsigned LIVES         = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  tile_game_sequencer_if.master bus
);

  localparam logic [23:0] STEP_P  = 24'(STEP_CYCLES);
  localparam logic [23:0] MIN_P   = 24'(MIN_STEP);
  localparam logic [23:0] DELTA_P = 24'(SPEEDUP_DELTA);
  localparam logic [7:0]  CD_LAST = 8'(COUNT_STEPS - 1);
  localparam logic [7:0]  HIT_LAST = 8'(SPEEDUP_HITS - 1);
  localparam logic [1:0]  LIVES_P = 2'(LIVES);
  localparam logic [9:0]  SCORE_MAX = 10'd999;

  logic        mk_valid;
  scan_t       mk_code;

  logic [2:0]  state_q, state_d;
  logic [9:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  scan_t       expected_q, expected_d;
  logic        pending_q, pending_d;
  logic        load_q, load_d;
  logic        step_q, step_d;
  logic [23:0] period_q, period_d;
  logic [23:0] period_nxt_q, period_nxt_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  cd_q, cd_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;

  logic        tick, start, space, pend, hit, miss;

  ps2_make_filter u_filter (
    .clk      (CLOCK_50),
    .rst_n    (reset),
    .data_en  (bus.received_data_en),
    .data     (bus.received_data),
    .mk_valid (mk_valid),
    .mk_code  (mk_code)
  );

  // Shortened period, clamped at the floor without wrapping below zero.
  function automatic logic [23:0] sped_up(input logic [23:0] p);
    if ({1'b0, p} >= ({1'b0, MIN_P} + {1'b0, DELTA_P})) return p - DELTA_P;
    else                                                 return MIN_P;
  endfunction

  assign space = mk_valid && (mk_code == SC_SPACE);
  assign tick  = ((state_q == GS_COUNTDOWN) || (state_q == GS_PLAY)) &&
                 (cnt_q == period_q - 24'd1);

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    expected_d   = expected_q;
    pending_d    = pending_q;
    load_d       = 1'b0;
    step_d       = 1'b0;
    period_d     = period_q;
    period_nxt_d = period_nxt_q;
    cnt_d        = cnt_q;
    cd_d         = cd_q;
    hit_cnt_d    = hit_cnt_q;
    start        = 1'b0;
    pend         = pending_q;
    hit          = 1'b0;
    miss         = 1'b0;

    case (state_q)
      GS_IDLE: start = space;

      GS_COUNTDOWN: begin
        if (tick) begin
          cnt_d = 24'd0;
          if (cd_q == CD_LAST) begin
            state_d = GS_PLAY;
            cd_d    = 8'd0;
          end else begin
            cd_d = cd_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      GS_PLAY: begin
        if (space) begin
          state_d = GS_PAUSE;
        end else begin
          // Key is judged against the tile on screen before the tick replaces it.
          if (mk_valid && is_note(mk_code)) begin
            if (pend && (mk_code == expected_q)) begin
              hit  = 1'b1;
              pend = 1'b0;
            end else begin
              miss = 1'b1;
            end
          end
          if (tick) begin
            cnt_d    = 24'd0;
            period_d = period_nxt_q;
            if (pend) miss = 1'b1;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
          pending_d = pend;

          if (hit) begin
            if (score_q != SCORE_MAX) score_d = score_q + 10'd1;
            if (hit_cnt_q == HIT_LAST) begin
              hit_cnt_d    = 8'd0;
              period_nxt_d = sped_up(period_nxt_q);
            end else begin
              hit_cnt_d = hit_cnt_q + 8'd1;
            end
          end

          if (miss) lives_d = lives_q - 2'd1;

          if (miss && (lives_q == 2'd1)) begin
            state_d    = GS_LOSE;
            expected_d = SC_EMPTY;
            pending_d  = 1'b0;
          end else if (tick) begin
            if (bus.chart_done && !pend) begin
              state_d    = GS_WIN;
              expected_d = SC_EMPTY;
            end else begin
              step_d     = 1'b1;
              expected_d = bus.chart_key;
              pending_d  = (bus.chart_key != SC_EMPTY);
            end
          end
        end
      end

      GS_PAUSE: if (space) state_d = GS_PLAY;

      GS_LOSE, GS_WIN: start = space;

      default: state_d = GS_IDLE;
    endcase

    if (start) begin
      state_d      = GS_COUNTDOWN;
      load_d       = 1'b1;
      score_d      = 10'd0;
      lives_d      = LIVES_P;
      period_d     = STEP_P;
      period_nxt_d = STEP_P;
      cnt_d        = 24'd0;
      cd_d         = 8'd0;
      hit_cnt_d    = 8'd0;
      expected_d   = SC_EMPTY;
      pending_d    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= GS_IDLE;
      score_q      <= 10'd0;
      lives_q      <= LIVES_P;
      expected_q   <= SC_EMPTY;
      pending_q    <= 1'b0;
      load_q       <= 1'b0;
      step_q       <= 1'b0;
      period_q     <= STEP_P;
      period_nxt_q <= STEP_P;
      cnt_q        <= 24'd0;
      cd_q         <= 8'd0;
      hit_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      expected_q   <= expected_d;
      pending_q    <= pending_d;
      load_q       <= load_d;
      step_q       <= step_d;
      period_q     <= period_d;
      period_nxt_q <= period_nxt_d;
      cnt_q        <= cnt_d;
      cd_q         <= cd_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  assign bus.chart_load = load_q;
  assign bus.chart_step = step_q;
  assign bus.expected   = expected_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.game_state = state_q;

endmodule

// File: tb/tb_tile_game_sequencer.sv
// Scoreboard bench: stimulus queues expected output events, a monitor pops and compares them.
module tb_tile_game_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_CD = 3'd1, S_PLAY = 3'd2,
                         S_PAUSE = 3'd3, S_LOSE = 3'd4, S_WIN = 3'd5;
  localparam logic [7:0] K_SPACE = 8'h29, K_A = 8'h1C, K_S = 8'h1B, K_F = 8'h2B,
                         K_W = 8'h1D, K_EMPTY = 8'h05, K_BRK = 8'hF0, K_EXT = 8'hE0;

  typedef struct {
    logic       load;
    logic       step;
    logic [2:0] st;
    logic [9:0] sc;
    logic [1:0] lv;
    logic [7:0] ex;
    int         gap;
  } ev_t;

  logic clk, rst_n;
  tile_game_sequencer_if bus ();

  ev_t   q[$];
  string nq[$];
  int    compared = 0;
  int    mismatched = 0;
  int    cyc = 0;
  int    ref_cyc = 0;
  int    gaps[6] = '{8, 8, 6, 6, 4, 4};
  logic [2:0] pst;
  logic [9:0] psc;
  logic [1:0] plv;

  tile_game_sequencer #(
    .STEP_CYCLES(8), .MIN_STEP(4), .SPEEDUP_HITS(2),
    .SPEEDUP_DELTA(2), .COUNT_STEPS(2), .LIVES(3)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string nm, input logic ld, input logic sp, input logic [2:0] s,
                      input logic [9:0] sc, input logic [1:0] lv, input logic [7:0] ex,
                      input int gap);
    ev_t e;
    e.load = ld; e.step = sp; e.st = s; e.sc = sc; e.lv = lv; e.ex = ex; e.gap = gap;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic check_ev(input int gap);
    ev_t e;
    string nm;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got load=%0d step=%0d st=%0d sc=%0d lv=%0d ex=%h, none queued",
               bus.chart_load, bus.chart_step, bus.game_state, bus.score, bus.lives, bus.expected);
      return;
    end
    e  = q.pop_front();
    nm = nq.pop_front();
    if (bus.chart_load !== e.load || bus.chart_step !== e.step || bus.game_state !== e.st ||
        bus.score !== e.sc || bus.lives !== e.lv || bus.expected !== e.ex ||
        (e.gap >= 0 && gap != e.gap)) begin
      mismatched++;
      $display("FAIL %s: got load=%0d step=%0d st=%0d sc=%0d lv=%0d ex=%h gap=%0d; want load=%0d step=%0d st=%0d sc=%0d lv=%0d ex=%h gap=%0d",
               nm, bus.chart_load, bus.chart_step, bus.game_state, bus.score, bus.lives,
               bus.expected, gap, e.load, e.step, e.st, e.sc, e.lv, e.ex, e.gap);
    end
  endtask

  // Monitor: an event is any pulse or any change of state, score or lives.
  initial begin : monitor
    logic chg, ref_ev;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        compared++;
        if (bus.chart_load !== 1'b0 || bus.chart_step !== 1'b0) begin
          mismatched++;
          $display("FAIL pulse_in_reset: got load=%0d step=%0d, want 0 0",
                   bus.chart_load, bus.chart_step);
        end
        ref_cyc = cyc;
      end else begin
        ref_ev = bus.chart_load || bus.chart_step || (bus.game_state !== pst);
        chg    = ref_ev || (bus.score !== psc) || (bus.lives !== plv);
        if (chg) check_ev(cyc - ref_cyc);
        if (ref_ev) ref_cyc = cyc;
      end
      pst = bus.game_state;
      psc = bus.score;
      plv = bus.lives;
    end
  end

  initial begin : reset_monitor
    forever begin
      @(negedge rst_n);
      #1;
      check_ev(-1);
    end
  end

  task automatic send(input logic [7:0] b);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(negedge clk);
    bus.received_data_en = 1'b0;
  endtask

  task automatic wait_step(input string nm);
    bit seen = 0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      seen = bus.chart_step;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s_timeout: got no chart_step in 64 cycles, want one", nm);
    end
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s);
    bit seen = 0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      seen = (bus.game_state == s);
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s_timeout: got state %0d, want %0d within 64 cycles", nm, bus.game_state, s);
    end
  endtask

  initial begin : watchdog
    #60000;
    mismatched++;
    $display("FAIL watchdog: got no end of stimulus, want completion before 60000 ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : stimulus
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    bus.chart_key        = K_A;
    bus.chart_done       = 1'b0;
    rst_n                = 1'b1;

    push("reset_init", 0, 0, S_IDLE, 0, 3, K_EMPTY, -1);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Game 1: start, hit, break filtering, miss with no tile, expiries to LOSE.
    push("g1_load", 1, 0, S_CD, 0, 3, K_EMPTY, -1);
    send(K_SPACE);
    push("g1_play", 0, 0, S_PLAY, 0, 3, K_EMPTY, 16);
    push("g1_step1", 0, 1, S_PLAY, 0, 3, K_A, 8);
    wait_step("g1_step1");
    push("g1_hit", 0, 0, S_PLAY, 1, 3, K_A, -1);
    send(K_A);
    bus.chart_key = K_S;
    send(K_BRK);
    send(K_A);
    send(K_W);
    push("g1_miss_nopend", 0, 0, S_PLAY, 1, 2, K_A, -1);
    send(K_A);
    push("g1_step2", 0, 1, S_PLAY, 1, 2, K_S, 8);
    push("g1_expire1", 0, 1, S_PLAY, 1, 1, K_S, 8);
    push("g1_lose", 0, 0, S_LOSE, 1, 0, K_EMPTY, 8);
    wait_state("g1_lose", S_LOSE);

    // Game 2: speed-up to the floor, pause/resume, hit on a tick, WIN.
    bus.chart_key = K_A;
    push("g2_load", 1, 0, S_CD, 0, 3, K_EMPTY, -1);
    send(K_SPACE);
    push("g2_play", 0, 0, S_PLAY, 0, 3, K_EMPTY, 16);
    push("g2_step1", 0, 1, S_PLAY, 0, 3, K_A, 8);
    wait_step("g2_step1");
    for (int i = 1; i <= 6; i++) begin
      push($sformatf("g2_hit%0d", i), 0, 0, S_PLAY, 10'(i), 3, K_A, -1);
      send(K_A);
      push($sformatf("g2_step%0d", i + 1), 0, 1, S_PLAY, 10'(i), 3, K_A, gaps[i-1]);
      wait_step("g2_step");
    end
    push("g2_hit7", 0, 0, S_PLAY, 7, 3, K_A, -1);
    send(K_A);
    push("g2_pause", 0, 0, S_PAUSE, 7, 3, K_A, -1);
    send(K_SPACE);
    bus.chart_key = K_F;
    send(K_S);
    repeat (4) @(negedge clk);
    push("g2_resume", 0, 0, S_PLAY, 7, 3, K_A, 6);
    send(K_SPACE);
    push("g2_step_after_pause", 0, 1, S_PLAY, 7, 3, K_F, 3);
    wait_step("g2_step_after_pause");
    bus.chart_key = K_A;
    repeat (3) @(negedge clk);
    push("g2_hit_on_tick", 0, 1, S_PLAY, 8, 3, K_A, 4);
    send(K_F);
    bus.chart_done = 1'b1;
    bus.chart_key  = K_EMPTY;
    push("g2_hit_last", 0, 0, S_PLAY, 9, 3, K_A, -1);
    send(K_A);
    push("g2_win", 0, 0, S_WIN, 9, 3, K_EMPTY, 4);
    wait_state("g2_win", S_WIN);

    // Game 3: restart from WIN, E0 prefix passes, three expiries to LOSE at period 8.
    bus.chart_done = 1'b0;
    bus.chart_key  = K_S;
    push("g3_load", 1, 0, S_CD, 0, 3, K_EMPTY, -1);
    send(K_SPACE);
    push("g3_play", 0, 0, S_PLAY, 0, 3, K_EMPTY, 16);
    push("g3_step1", 0, 1, S_PLAY, 0, 3, K_S, 8);
    wait_step("g3_step1");
    send(K_EXT);
    push("g3_hit_ext", 0, 0, S_PLAY, 1, 3, K_S, -1);
    send(K_S);
    send(K_W);
    push("g3_step2", 0, 1, S_PLAY, 1, 3, K_S, 8);
    push("g3_expire1", 0, 1, S_PLAY, 1, 2, K_S, 8);
    push("g3_expire2", 0, 1, S_PLAY, 1, 1, K_S, 8);
    push("g3_lose", 0, 0, S_LOSE, 1, 0, K_EMPTY, 8);
    wait_state("g3_lose", S_LOSE);

    // Game 4: asynchronous reset in the middle of PLAY.
    bus.chart_key = K_A;
    push("g4_load", 1, 0, S_CD, 0, 3, K_EMPTY, -1);
    send(K_SPACE);
    push("g4_play", 0, 0, S_PLAY, 0, 3, K_EMPTY, 16);
    push("g4_step1", 0, 1, S_PLAY, 0, 3, K_A, 8);
    wait_step("g4_step1");
    push("g4_hit", 0, 0, S_PLAY, 1, 3, K_A, -1);
    send(K_A);
    push("reset_mid_play", 0, 0, S_IDLE, 0, 3, K_EMPTY, -1);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drained: got %0d pending events (next %s), want 0", q.size(), nq[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
